// File: rtl/alu_mem_sequencer_if.sv
// Requester, ALU and memory signals of alu_mem_sequencer, bundled with
// the sequencer (slave) and environment (master) views.
interface alu_mem_sequencer_if #(
    parameter int DW  = 16,
    parameter int AW  = 15,
    parameter int OPW = 4
);
    logic           req0, req1;
    logic [OPW-1:0] op0, op1;
    logic [DW-1:0]  a0, b0, a1, b1;
    logic [AW-1:0]  addr0, addr1;
    logic           wr0, wr1;
    logic           ack0, ack1;
    logic           done0, done1;
    logic [DW-1:0]  rdata;
    logic           busy;
    logic [DW-1:0]  alu_a, alu_b, alu_y;
    logic [OPW-1:0] alu_op;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_din, mem_dout;
    logic           mem_we;

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1, addr0, addr1, wr0, wr1,
        input  alu_y, mem_dout,
        output ack0, ack1, done0, done1, rdata, busy,
        output alu_a, alu_b, alu_op, mem_addr, mem_din, mem_we
    );

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1, addr0, addr1, wr0, wr1,
        output alu_y, mem_dout,
        input  ack0, ack1, done0, done1, rdata, busy,
        input  alu_a, alu_b, alu_op, mem_addr, mem_din, mem_we
    );
endinterface

// File: rtl/alu_mem_sequencer.sv
// Round-robin sequencer sharing one ALU and one data memory between two ports.
// Define ALU_MEM_SEQ_READBACK_EN to compile in the READ (memory readback) state.
module alu_mem_sequencer #(
    parameter int DW  = 16,
    parameter int AW  = 15,
    parameter int OPW = 4
) (
    input  logic               clk,
    input  logic               rst,
    alu_mem_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_WRITE,
`ifdef ALU_MEM_SEQ_READBACK_EN
        S_READ,
`endif
        S_DONE
    } state_t;

    state_t        state;
    logic          lsp;     // last-served port
    logic          sel;     // port currently being served
    logic [AW-1:0] addr_q;
    logic          wr_q;
    logic [DW-1:0] res;
    logic          pick;

    // NOTE: pick is assigned on every path, so this stays pure logic with no latch.
    always_comb begin
        pick = (bus.req0 && bus.req1) ? ~lsp : bus.req1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            lsp          <= 1'b1;
            sel          <= 1'b0;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            res          <= '0;
            bus.ack0     <= 1'b0;
            bus.ack1     <= 1'b0;
            bus.done0    <= 1'b0;
            bus.done1    <= 1'b0;
            bus.rdata    <= '0;
            bus.busy     <= 1'b0;
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.alu_op   <= '0;
            bus.mem_addr <= '0;
            bus.mem_din  <= '0;
            bus.mem_we   <= 1'b0;
        end else begin
            // NOTE: pulses default low here and are raised only for the one cycle that needs them.
            bus.ack0   <= 1'b0;
            bus.ack1   <= 1'b0;
            bus.done0  <= 1'b0;
            bus.done1  <= 1'b0;
            bus.mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        sel        <= pick;
                        bus.alu_op <= pick ? bus.op1   : bus.op0;
                        bus.alu_a  <= pick ? bus.a1    : bus.a0;
                        bus.alu_b  <= pick ? bus.b1    : bus.b0;
                        addr_q     <= pick ? bus.addr1 : bus.addr0;
                        wr_q       <= pick ? bus.wr1   : bus.wr0;
                        bus.ack0   <= ~pick;
                        bus.ack1   <= pick;
                        bus.busy   <= 1'b1;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // mem_din takes alu_y directly so it equals res during WRITE
                    res          <= bus.alu_y;
                    bus.mem_addr <= addr_q;
                    bus.mem_din  <= bus.alu_y;
                    bus.mem_we   <= wr_q;
                    state        <= S_WRITE;
                end
                S_WRITE: begin
`ifdef ALU_MEM_SEQ_READBACK_EN
                    state     <= S_READ;
`else
                    bus.rdata <= res;
                    bus.done0 <= ~sel;
                    bus.done1 <= sel;
                    state     <= S_DONE;
`endif
                end
`ifdef ALU_MEM_SEQ_READBACK_EN
                S_READ: begin
                    // memory returns the just-written word this cycle
                    if (wr_q) begin
                        res       <= bus.mem_dout;
                        bus.rdata <= bus.mem_dout;
                    end else begin
                        bus.rdata <= res;
                    end
                    bus.done0 <= ~sel;
                    bus.done1 <= sel;
                    state     <= S_DONE;
                end
`endif
                S_DONE: begin
                    lsp      <= sel;
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
